// File: rtl/fba_pkg.sv
// Shared definitions for the flop bank arbiter: FSM state encoding and hold counter width.
package fba_pkg;

  typedef enum logic [1:0] {
    FBA_IDLE  = 2'd0,
    FBA_WRITE = 2'd1,
    FBA_HOLD  = 2'd2
  } fba_state_e;

  localparam int unsigned FBA_CNT_W = 4;

endpackage

// File: rtl/fba_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module fba_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] ireq,
  input  logic [IDX_W-1:0] iptr,
  output logic [N_REQ-1:0] owinner_c,
  output logic [IDX_W-1:0] oidx_c,
  output logic             ovalid_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    cand      = '0;
    owinner_c = '0;
    oidx_c    = '0;
    ovalid_c  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(iptr) + i) % N_REQ);
      if (!ovalid_c && ireq[cand]) begin
        ovalid_c = 1'b1;
        oidx_c   = cand;
      end
    end
    owinner_c[oidx_c] = ovalid_c;
  end

endmodule

// File: rtl/flop_bank_arbiter.sv
// Round-robin sequencer loading one shared WIDTH-bit register from N_REQ requesters.
// Optional back-to-back locking of the current grant is enabled with `define FBA_LOCK_EN.
module flop_bank_arbiter
  import fba_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 2
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic [N_REQ-1:0]       ireq,
  input  logic [N_REQ*WIDTH-1:0] idata,
`ifdef FBA_LOCK_EN
  input  logic [N_REQ-1:0]       ilock,
`endif
  output logic [N_REQ-1:0]       ogrant,
  output logic [N_REQ-1:0]       oack,
  output logic [WIDTH-1:0]       oQ,
  output logic [WIDTH-1:0]       oQN,
  output logic                   obusy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  fba_state_e           state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [FBA_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic [N_REQ-1:0]     win_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 win_valid_c;
  logic [IDX_W-1:0]     next_ptr_c;
  logic                 lock_c;
  logic [WIDTH-1:0]     lane [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = idata[i*WIDTH +: WIDTH];
  end

  fba_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .ireq      (ireq),
    .iptr      (ptr_q),
    .owinner_c (win_c),
    .oidx_c    (win_idx_c),
    .ovalid_c  (win_valid_c)
  );

  assign next_ptr_c = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + IDX_W'(1);

`ifdef FBA_LOCK_EN
  assign lock_c = ilock[g_q] & ireq[g_q];
`else
  assign lock_c = 1'b0;
`endif

  // Next-state and datapath: one load per grant, then cooldown unless the grant is locked.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    q_d     = q_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FBA_IDLE: begin
        if (win_valid_c) begin
          grant_d = win_c;
          g_d     = win_idx_c;
          state_d = FBA_WRITE;
        end
      end
      FBA_WRITE: begin
        ptr_d = next_ptr_c;
        if (ireq[g_q]) begin
          q_d   = lane[g_q];
          ack_d = grant_q;
          if (HOLD == 0) begin
            if (!lock_c) begin
              grant_d = '0;
              state_d = FBA_IDLE;
            end
          end else begin
            cnt_d   = FBA_CNT_W'(HOLD);
            state_d = FBA_HOLD;
          end
        end else begin
          // Requester withdrew before the load: abort without ack.
          grant_d = '0;
          state_d = FBA_IDLE;
        end
      end
      FBA_HOLD: begin
        if (cnt_q <= FBA_CNT_W'(1)) begin
          if (lock_c) begin
            state_d = FBA_WRITE;
          end else begin
            grant_d = '0;
            state_d = FBA_IDLE;
          end
        end else begin
          cnt_d = cnt_q - FBA_CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = FBA_IDLE;
      end
    endcase
    busy_d = (state_d != FBA_IDLE);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= FBA_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign ogrant = grant_q;
  assign oack   = ack_q;
  assign oQ     = q_q;
  assign oQN    = ~q_q;
  assign obusy  = busy_q;

endmodule

// File: tb/tb_flop_bank_arbiter.sv
// Self-checking bench for flop_bank_arbiter; expected loads are queued and matched on each ack.
module tb_flop_bank_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   ireq;
  logic [N*W-1:0] idata;
  logic [N-1:0]   ilock;
  logic [N-1:0]   ogrant;
  logic [N-1:0]   oack;
  logic [W-1:0]   oQ;
  logic [W-1:0]   oQN;
  logic           obusy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  flop_bank_arbiter #(
    .N_REQ (N),
    .WIDTH (W),
    .HOLD  (2)
  ) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .ireq   (ireq),
    .idata  (idata),
`ifdef FBA_LOCK_EN
    .ilock  (ilock),
`endif
    .ogrant (ogrant),
    .oack   (oack),
    .oQ     (oQ),
    .oQN    (oQN),
    .obusy  (obusy)
  );

  task automatic set_lane(input int i, input logic [W-1:0] v);
    idata[i*W +: W] = v;
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] v);
    exp_t e;
    e.idx  = 2'(i);
    e.data = v;
    sb.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit later, and retire any ack against the queue.
  task automatic step();
    exp_t         e;
    logic [N-1:0] exp_ack;
    @(posedge clk);
    #1;
    cyc++;
    if (oack != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack: oack=%b oQ=%h, nothing expected", oack, oQ);
      end else begin
        e       = sb.pop_front();
        exp_ack = N'(1) << e.idx;
        if (oack !== exp_ack || oQ !== e.data || oQN !== ~e.data) begin
          errors++;
          $display("FAIL sb_load: oack=%b oQ=%h oQN=%h, expected oack=%b oQ=%h oQN=%h",
                   oack, oQ, oQN, exp_ack, e.data, ~e.data);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (obusy && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (obusy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: obusy=%b, expected 0", name, obusy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ireq  = '0;
    ilock = '0;
    idata = '0;
    #3;
    checks++;
    if (ogrant !== '0 || oack !== '0 || oQ !== 8'h00 || oQN !== 8'hFF || obusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b ack=%b oQ=%h oQN=%h busy=%b, expected 0000 0000 00 ff 0",
               ogrant, oack, oQ, oQN, obusy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (ogrant !== '0 || obusy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: grant=%b busy=%b, expected 0000 0", ogrant, obusy);
    end
  endtask

  task automatic test_single();
    set_lane(2, 8'hA5);
    ireq = 4'b0100;
    step();
    checks++;
    if (ogrant !== 4'b0100 || oack !== '0 || obusy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b ack=%b busy=%b, expected 0100 0000 1", ogrant, oack, obusy);
    end
    push_exp(2, 8'hA5);
    step();
    checks++;
    if (oQ !== 8'hA5 || oack !== 4'b0100) begin
      errors++;
      $display("FAIL single_load: oQ=%h ack=%b, expected a5 0100", oQ, oack);
    end
    ireq = '0;
    step();
    checks++;
    if (ogrant !== 4'b0100 || oack !== '0 || obusy !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: grant=%b ack=%b busy=%b, expected 0100 0000 1", ogrant, oack, obusy);
    end
    step();
    checks++;
    if (ogrant !== '0 || obusy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b, expected 0000 0", ogrant, obusy);
    end
  endtask

  task automatic test_reset_mid_hold();
    set_lane(0, 8'h3C);
    ireq = 4'b0001;
    step();
    push_exp(0, 8'h3C);
    step();
    ireq = '0;
    step();
    checks++;
    if (ogrant !== 4'b0001 || obusy !== 1'b1 || oQ !== 8'h3C) begin
      errors++;
      $display("FAIL pre_reset_hold: grant=%b busy=%b oQ=%h, expected 0001 1 3c", ogrant, obusy, oQ);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ogrant !== '0 || oack !== '0 || oQ !== 8'h00 || oQN !== 8'hFF || obusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: grant=%b ack=%b oQ=%h oQN=%h busy=%b, expected 0000 0000 00 ff 0",
               ogrant, oack, oQ, oQN, obusy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_req();
    int n    = 0;
    int last = 0;
    int g    = 0;
    set_lane(0, 8'h11);
    set_lane(1, 8'h22);
    set_lane(2, 8'h33);
    set_lane(3, 8'h44);
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    push_exp(2, 8'h33);
    push_exp(3, 8'h44);
    push_exp(0, 8'h11);
    ireq = 4'b1111;
    while (n < 5 && g < 40) begin
      step();
      g++;
      if (oack != '0) begin
        if (n > 0) begin
          checks++;
          if (cyc - last != 4) begin
            errors++;
            $display("FAIL all_req_spacing: ack %0d came %0d cycles after previous, expected 4", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n == 5) ireq = '0;
      end
    end
    ireq = '0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL all_req_count: saw %0d acks, expected 5", n);
    end
    wait_idle("all_req");
  endtask

  task automatic test_abort();
    set_lane(1, 8'h77);
    set_lane(2, 8'h99);
    ireq = 4'b0110;
    step();
    checks++;
    if (ogrant !== 4'b0010) begin
      errors++;
      $display("FAIL abort_grant: grant=%b, expected 0010", ogrant);
    end
    ireq = 4'b0100;
    step();
    checks++;
    if (ogrant !== '0 || oack !== '0 || oQ !== 8'h11 || obusy !== 1'b0) begin
      errors++;
      $display("FAIL abort_noload: grant=%b ack=%b oQ=%h busy=%b, expected 0000 0000 11 0",
               ogrant, oack, oQ, obusy);
    end
    push_exp(2, 8'h99);
    step();
    checks++;
    if (ogrant !== 4'b0100) begin
      errors++;
      $display("FAIL abort_next_grant: grant=%b, expected 0100", ogrant);
    end
    step();
    ireq = '0;
    checks++;
    if (oQ !== 8'h99) begin
      errors++;
      $display("FAIL abort_next_load: oQ=%h, expected 99", oQ);
    end
    wait_idle("abort");
  endtask

  task automatic test_wrap();
    int n = 0;
    set_lane(3, 8'hC3);
    set_lane(0, 8'h3D);
    push_exp(3, 8'hC3);
    push_exp(0, 8'h3D);
    ireq = 4'b1001;
    step();
    checks++;
    if (ogrant !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_first: grant=%b, expected 1000", ogrant);
    end
    step();
    ireq = 4'b0001;
    while (ogrant !== 4'b0001 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL wrap_second: grant 0001 after %0d cycles (grant=%b), expected 3", n, ogrant);
    end
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
    end
    ireq = '0;
    wait_idle("wrap");
  endtask

`ifdef FBA_LOCK_EN
  task automatic test_back_to_back();
    int n    = 0;
    int g    = 0;
    int last = 0;
    set_lane(0, 8'h5A);
    set_lane(1, 8'hE1);
    ilock = 4'b0001;
    ireq  = 4'b0001;
    push_exp(0, 8'h5A);
    push_exp(0, 8'h5A);
    push_exp(0, 8'h5A);
    step();
    ireq = 4'b0011;
    while (n < 3 && g < 30) begin
      step();
      g++;
      checks++;
      if (ogrant !== 4'b0001) begin
        errors++;
        $display("FAIL lock_grant_held: grant=%b, expected 0001", ogrant);
      end
      if (oack != '0) begin
        if (n > 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL lock_spacing: load %0d came %0d cycles after previous, expected 3", n, cyc - last);
          end
        end
        last = cyc;
        n++;
      end
    end
    ilock = '0;
    ireq  = 4'b0010;
    push_exp(1, 8'hE1);
    g = 0;
    while (ogrant !== 4'b0010 && g < 10) begin
      step();
      g++;
    end
    checks++;
    if (ogrant !== 4'b0010) begin
      errors++;
      $display("FAIL lock_release_grant: grant=%b, expected 0010", ogrant);
    end
    step();
    ireq = '0;
    wait_idle("lock");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_reset_mid_hold();
    test_all_req();
    test_abort();
    test_wrap();
`ifdef FBA_LOCK_EN
    test_back_to_back();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_missing_acks: %0d expected loads never acked", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
